// File: rtl/simple_axi_write_arbiter_if.sv
// Simple write-port bundle between Versat requesters, the write arbiter and the converter.
// slave = arbiter view; master = requester/converter side view.
interface simple_axi_write_arbiter_if #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned LEN_W      = 8
);
    logic [N_REQ-1:0]              req_wvalid;
    logic [N_REQ-1:0]              req_wready;
    logic [N_REQ*AXI_ADDR_W-1:0]   req_waddr;
    logic [N_REQ*AXI_DATA_W-1:0]   req_wdata;
    logic [N_REQ*AXI_DATA_W/8-1:0] req_wstrb;
    logic [N_REQ*LEN_W-1:0]        req_wlen;
    logic [N_REQ-1:0]              req_wlast;

    logic                    m_wvalid;
    logic                    m_wready;
    logic [AXI_ADDR_W-1:0]   m_waddr;
    logic [AXI_DATA_W-1:0]   m_wdata;
    logic [AXI_DATA_W/8-1:0] m_wstrb;
    logic [LEN_W-1:0]        m_wlen;
    logic                    m_wlast;

    modport slave (
        input  req_wvalid, req_waddr, req_wdata, req_wstrb, req_wlen, m_wready, m_wlast,
        output req_wready, req_wlast, m_wvalid, m_waddr, m_wdata, m_wstrb, m_wlen
    );

    modport master (
        output req_wvalid, req_waddr, req_wdata, req_wstrb, req_wlen, m_wready, m_wlast,
        input  req_wready, req_wlast, m_wvalid, m_waddr, m_wdata, m_wstrb, m_wlen
    );
endinterface

// File: rtl/simple_axi_write_arbiter.sv
// Whole-transfer write arbiter sharing one simple write port among N_REQ requesters.
// Round-robin by default; define VERSAT_WRITE_ARB_FIXED_PRIO_EN for lowest-index-wins priority.
module simple_axi_write_arbiter #(
    parameter int unsigned N_REQ      = 4,
    parameter int unsigned AXI_ADDR_W = 32,
    parameter int unsigned AXI_DATA_W = 32,
    parameter int unsigned LEN_W      = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    simple_axi_write_arbiter_if.slave    bus,
    output logic [N_REQ-1:0]             grant,
    output logic                         busy
);
    localparam int unsigned IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned STRB_W = AXI_DATA_W / 8;

    typedef enum logic [0:0] {StIdle, StOwned} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] winner;

`ifdef VERSAT_WRITE_ARB_FIXED_PRIO_EN
    always_comb begin
        winner = '0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (bus.req_wvalid[i]) winner = IDX_W'(i);
        end
    end
`else
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [IDX_W:0]   cand;
    logic             found;

    // Search upward from rr_ptr, wrapping N_REQ-1 -> 0.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        cand   = '0;
        for (int unsigned off = 0; off < N_REQ; off++) begin
            cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N_REQ)) cand = cand - (IDX_W+1)'(N_REQ);
            if (!found && bus.req_wvalid[cand[IDX_W-1:0]]) begin
                found  = 1'b1;
                winner = cand[IDX_W-1:0];
            end
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == StOwned && bus.m_wlast) begin
            rr_ptr_d = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr_q <= '0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        case (state_q)
            StIdle: begin
                if (|bus.req_wvalid) begin
                    state_d = StOwned;
                    owner_d = winner;
                end
            end
            StOwned: begin
                if (bus.m_wlast) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
        end
    end

    // Outputs depend only on registered state/owner, so no req_wvalid -> m_wvalid path in IDLE.
    always_comb begin
        grant          = '0;
        busy           = 1'b0;
        bus.m_wvalid   = 1'b0;
        bus.m_waddr    = '0;
        bus.m_wdata    = '0;
        bus.m_wstrb    = '0;
        bus.m_wlen     = '0;
        bus.req_wready = '0;
        bus.req_wlast  = '0;
        if (state_q == StOwned) begin
            grant[owner_q]          = 1'b1;
            busy                    = 1'b1;
            bus.m_wvalid            = bus.req_wvalid[owner_q];
            bus.m_waddr             = bus.req_waddr[owner_q*AXI_ADDR_W +: AXI_ADDR_W];
            bus.m_wdata             = bus.req_wdata[owner_q*AXI_DATA_W +: AXI_DATA_W];
            bus.m_wstrb             = bus.req_wstrb[owner_q*STRB_W +: STRB_W];
            bus.m_wlen              = bus.req_wlen[owner_q*LEN_W +: LEN_W];
            bus.req_wready[owner_q] = bus.m_wready;
            bus.req_wlast[owner_q]  = bus.m_wlast;
        end
    end
endmodule

// File: tb/tb_simple_axi_write_arbiter.sv
// Directed self-checking bench for simple_axi_write_arbiter (N_REQ=4, 32-bit addr/data, 8-bit len).
// Follows VERSAT_WRITE_ARB_FIXED_PRIO_EN the same way as the design.
module tb_simple_axi_write_arbiter;
    localparam int unsigned N = 4;

    logic         clk;
    logic         rst;
    logic [N-1:0] grant;
    logic         busy;
    int           n_cmp = 0;
    int           n_bad = 0;

    simple_axi_write_arbiter_if #(.N_REQ(N), .AXI_ADDR_W(32), .AXI_DATA_W(32), .LEN_W(8)) bus ();

    simple_axi_write_arbiter #(
        .N_REQ     (N),
        .AXI_ADDR_W(32),
        .AXI_DATA_W(32),
        .LEN_W     (8)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .grant(grant),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input logic [7:0] l);
        bus.req_wvalid[i]         = v;
        bus.req_waddr[i*32 +: 32] = a;
        bus.req_wdata[i*32 +: 32] = d;
        bus.req_wstrb[i*4 +: 4]   = s;
        bus.req_wlen[i*8 +: 8]    = l;
    endtask

    // One IDLE cycle: nothing granted yet even if requests are pending.
    task automatic idle_cycle(input string tag);
        #1;
        check({tag, "_idle_busy"}, 64'(busy), 64'd0);
        check({tag, "_idle_grant"}, 64'(grant), 64'd0);
        check({tag, "_idle_mvalid"}, 64'(bus.m_wvalid), 64'd0);
        tick();
    endtask

    task automatic xfer(input string tag, input int beats, input logic [N-1:0] exp_g);
        bus.m_wready = 1'b1;
        for (int b = 0; b < beats; b++) begin
            bus.m_wlast = (b == beats - 1);
            #1;
            check({tag, "_grant"}, 64'(grant), 64'(exp_g));
            check({tag, "_mvalid"}, 64'(bus.m_wvalid), 64'd1);
            check({tag, "_rready"}, 64'(bus.req_wready), 64'(exp_g));
            check({tag, "_rlast"}, 64'(bus.req_wlast), (b == beats - 1) ? 64'(exp_g) : 64'd0);
            tick();
        end
        bus.m_wlast = 1'b0;
    endtask

    initial begin
        logic [4:0] wr_pat;
        logic [N-1:0] fair_exp [5];
        int acc;

        rst            = 1'b1;
        bus.req_wvalid = '0;
        bus.req_waddr  = '0;
        bus.req_wdata  = '0;
        bus.req_wstrb  = '0;
        bus.req_wlen   = '0;
        bus.m_wready   = 1'b0;
        bus.m_wlast    = 1'b0;
        set_req(1, 1'b1, 32'h40, 32'h1, 4'hF, 8'd4);
        #12;
        check("rst_grant", 64'(grant), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_mvalid", 64'(bus.m_wvalid), 64'd0);
        check("rst_rready", 64'(bus.req_wready), 64'd0);
        bus.req_wvalid = '0;
        tick();
        rst = 1'b0;
        tick();

`ifndef VERSAT_WRITE_ARB_FIXED_PRIO_EN
        // Fairness from rr_ptr=0: 0,1,2,3,0 with one idle cycle between grants.
        fair_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 32'(i * 16'h100), 32'(i), 4'hF, 8'd4);
        idle_cycle("fair0");
        for (int k = 0; k < 5; k++) begin
            xfer($sformatf("fair%0d", k), 1, fair_exp[k]);
            if (k == 4) bus.req_wvalid = '0;
            idle_cycle($sformatf("fair_gap%0d", k));
        end
`endif

        // Single requester 2, four beats.
        set_req(2, 1'b1, 32'h100, 32'hA000_0000, 4'hF, 8'd16);
        bus.m_wready = 1'b1;
        idle_cycle("single");
        for (int k = 0; k < 4; k++) begin
            set_req(2, 1'b1, 32'h100, 32'hA000_0000 + 32'(k), 4'hF, 8'd16);
            bus.m_wlast = (k == 3);
            #1;
            check("single_grant", 64'(grant), 64'h4);
            check("single_mvalid", 64'(bus.m_wvalid), 64'd1);
            check("single_addr", 64'(bus.m_waddr), 64'h100);
            check("single_data", 64'(bus.m_wdata), 64'hA000_0000 + 64'(k));
            check("single_strb", 64'(bus.m_wstrb), 64'hF);
            check("single_len", 64'(bus.m_wlen), 64'd16);
            check("single_rready", 64'(bus.req_wready), 64'h4);
            check("single_rlast", 64'(bus.req_wlast), (k == 3) ? 64'h4 : 64'h0);
            tick();
        end
        bus.m_wlast    = 1'b0;
        bus.req_wvalid = '0;
        idle_cycle("single_end");

`ifndef VERSAT_WRITE_ARB_FIXED_PRIO_EN
        // rr_ptr=3 now: 3 wins over 1, then 1; after owner 3 alone, lone req 1 wins.
        set_req(1, 1'b1, 32'h200, 32'h11, 4'hF, 8'd4);
        set_req(3, 1'b1, 32'h300, 32'h33, 4'hF, 8'd4);
        idle_cycle("wrap_a");
        xfer("wrap_3", 1, 4'b1000);
        idle_cycle("wrap_b");
        xfer("wrap_1", 1, 4'b0010);
        bus.req_wvalid = 4'b1000;
        idle_cycle("wrap_c");
        xfer("wrap_3b", 1, 4'b1000);
        bus.req_wvalid = 4'b0010;
        idle_cycle("wrap_d");
        xfer("wrap_1b", 1, 4'b0010);
        bus.req_wvalid = '0;
        idle_cycle("wrap_end");
`endif

        // Backpressure: owner 0, requester 1 waiting; m_wready 1,0,1,0,1.
        wr_pat = 5'b10101;
        acc    = 0;
        set_req(0, 1'b1, 32'h500, 32'hB0, 4'h3, 8'd12);
        set_req(1, 1'b1, 32'h600, 32'hC0, 4'hF, 8'd4);
        idle_cycle("bp");
        for (int c = 0; c < 5; c++) begin
            bus.m_wready = wr_pat[c];
            bus.m_wlast  = wr_pat[c] && (acc == 2);
            set_req(0, 1'b1, 32'h500, 32'hB0 + 32'(acc), 4'h3, 8'd12);
            #1;
            check("bp_grant", 64'(grant), 64'h1);
            check("bp_rready", 64'(bus.req_wready), wr_pat[c] ? 64'h1 : 64'h0);
            check("bp_addr", 64'(bus.m_waddr), 64'h500);
            check("bp_data", 64'(bus.m_wdata), 64'hB0 + 64'(acc));
            check("bp_strb", 64'(bus.m_wstrb), 64'h3);
            check("bp_rlast", 64'(bus.req_wlast), (c == 4) ? 64'h1 : 64'h0);
            tick();
            if (wr_pat[c]) acc++;
        end
        bus.m_wlast    = 1'b0;
        bus.m_wready   = 1'b1;
        bus.req_wvalid = '0;
        idle_cycle("bp_end");

        // Reset during beat 2 of 4; afterwards req 0 beats req 2 from rr_ptr=0.
        set_req(2, 1'b1, 32'h700, 32'hD0, 4'hF, 8'd16);
        idle_cycle("rst_mid");
        #1;
        check("rstm_beat1_grant", 64'(grant), 64'h4);
        tick();
        rst = 1'b1;
        #1;
        check("rstm_grant", 64'(grant), 64'h0);
        check("rstm_busy", 64'(busy), 64'd0);
        check("rstm_mvalid", 64'(bus.m_wvalid), 64'd0);
        tick();
        set_req(0, 1'b1, 32'h800, 32'hE0, 4'hF, 8'd4);
        rst = 1'b0;
        idle_cycle("rst_rel");
        xfer("rst_after", 1, 4'b0001);
        bus.req_wvalid = '0;
        idle_cycle("rst_end");

`ifdef VERSAT_WRITE_ARB_FIXED_PRIO_EN
        // Fixed priority: req 0 always beats req 3 until it drops.
        set_req(0, 1'b1, 32'h900, 32'hF0, 4'hF, 8'd4);
        set_req(3, 1'b1, 32'hA00, 32'hF3, 4'hF, 8'd4);
        for (int k = 0; k < 3; k++) begin
            idle_cycle($sformatf("fp%0d", k));
            xfer($sformatf("fp_own0_%0d", k), 1, 4'b0001);
        end
        bus.req_wvalid[0] = 1'b0;
        idle_cycle("fp_drop");
        xfer("fp_own3", 1, 4'b1000);
        bus.req_wvalid = '0;
        idle_cycle("fp_end");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
